traffic_light_conflict_monitor: RTL and testbench

- Sits on the output side of the traffic light controller FSM. It consumes the 2-bit highway and farm light codes and drives the discrete lamp outputs (red/yellow/green per approach).
- It also checks the light sequence against safety rules. On any violation it latches a fault and forces a flashing-red fail-safe until an explicit clear.

---
 rtl/traffic_light_conflict_monitor_if.sv | 34 +++
 rtl/traffic_light_conflict_monitor.sv | 186 ++++++++++++++++++
 tb/tb_traffic_light_conflict_monitor.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/traffic_light_conflict_monitor_if.sv
// rtl/traffic_light_conflict_monitor_if.sv - light-code inputs and lamp/fault outputs of the conflict monitor
// Optional fault_count signal present only when TLCM_FAULT_COUNT_EN is defined.
interface traffic_light_conflict_monitor_if;
   logic [1:0] highway_light;
   logic [1:0] farm_light;
   logic       clear_fault;
   logic       hw_red;
   logic       hw_yel;
   logic       hw_grn;
   logic       fm_red;
   logic       fm_yel;
   logic       fm_grn;
   logic       fault;
   logic [1:0] fault_code;
`ifdef TLCM_FAULT_COUNT_EN
   logic [7:0] fault_count;
`endif

   modport master (
      output highway_light, farm_light, clear_fault,
      input  hw_red, hw_yel, hw_grn, fm_red, fm_yel, fm_grn, fault, fault_code
`ifdef TLCM_FAULT_COUNT_EN
      , input fault_count
`endif
   );

   modport slave (
      input  highway_light, farm_light, clear_fault,
      output hw_red, hw_yel, hw_grn, fm_red, fm_yel, fm_grn, fault, fault_code
`ifdef TLCM_FAULT_COUNT_EN
      , output fault_count
`endif
   );
endinterface

// File: rtl/traffic_light_conflict_monitor.sv
// rtl/traffic_light_conflict_monitor.sv - lamp driver with light-sequence safety checks and flashing-red fail-safe
// Define TLCM_FAULT_COUNT_EN to add the saturating fault_count output.
module traffic_light_conflict_monitor #(
   parameter int MIN_YELLOW  = 3,
   parameter int INVALID_TOL = 2,
   parameter int FLASH_HALF  = 8
) (
   input logic                             clk,
   input logic                             rst,
   traffic_light_conflict_monitor_if.slave bus
);
   typedef enum logic {ST_MON, ST_FLASH} state_t;

   localparam logic [1:0] C_GRN = 2'b00;
   localparam logic [1:0] C_YEL = 2'b01;
   localparam logic [1:0] C_RED = 2'b10;
   localparam logic [1:0] C_INV = 2'b11;

   localparam logic [1:0] FC_CONFLICT = 2'b00;
   localparam logic [1:0] FC_ILLEGAL  = 2'b01;
   localparam logic [1:0] FC_SHORT_Y  = 2'b10;
   localparam logic [1:0] FC_INVALID  = 2'b11;

   localparam int YW = $clog2(MIN_YELLOW + 1);
   localparam int IW = $clog2(INVALID_TOL + 1);
   localparam int FW = $clog2(FLASH_HALF + 1);
   localparam logic [YW-1:0] YMAX  = YW'(MIN_YELLOW);
   localparam logic [IW-1:0] IMAX  = IW'(INVALID_TOL);
   localparam logic [FW-1:0] FLAST = FW'(FLASH_HALF - 1);

   // Index 0 is the highway approach, index 1 the farm approach.
   state_t        r_state, w_state;
   logic [1:0]    r_prev [2];
   logic [1:0]    w_prev [2];
   logic [YW-1:0] r_ycnt [2];
   logic [YW-1:0] w_ycnt [2];
   logic [IW-1:0] r_icnt [2];
   logic [IW-1:0] w_icnt [2];
   logic [1:0]    r_red, w_red;
   logic [1:0]    r_yel, w_yel;
   logic [1:0]    r_grn, w_grn;
   logic          r_fault, w_fault;
   logic [1:0]    r_fcode, w_fcode;
   logic [FW-1:0] r_flash, w_flash;
`ifdef TLCM_FAULT_COUNT_EN
   logic [7:0]    r_fault_count, w_fault_count;
`endif

   logic [1:0]    w_code [2];
   logic          w_conflict;
   logic [1:0]    w_short;
   logic [1:0]    w_illegal;
   logic [1:0]    w_inv_over;
   logic          w_violation;
   logic          w_clear_ok;

   always_comb begin
      w_code[0]  = bus.highway_light;
      w_code[1]  = bus.farm_light;
      w_conflict = ((w_code[0] == C_GRN) || (w_code[0] == C_YEL)) &&
                   ((w_code[1] == C_GRN) || (w_code[1] == C_YEL));
      for (int a = 0; a < 2; a++) begin
         w_short[a]    = (r_prev[a] == C_YEL) && (w_code[a] == C_RED) && (r_ycnt[a] < YMAX);
         w_illegal[a]  = ((r_prev[a] == C_GRN) && (w_code[a] == C_RED)) ||
                         ((r_prev[a] == C_YEL) && (w_code[a] == C_GRN)) ||
                         ((r_prev[a] == C_RED) && (w_code[a] == C_YEL));
         w_inv_over[a] = (w_code[a] == C_INV) && (r_icnt[a] == IMAX);
      end
      w_violation = w_conflict || (|w_short) || (|w_illegal) || (|w_inv_over);
      w_clear_ok  = bus.clear_fault && (w_code[0] == C_RED) && (w_code[1] == C_RED);
   end

   always_comb begin
      w_state = r_state;
      w_prev  = r_prev;
      w_ycnt  = r_ycnt;
      w_icnt  = r_icnt;
      w_red   = r_red;
      w_yel   = r_yel;
      w_grn   = r_grn;
      w_fault = r_fault;
      w_fcode = r_fcode;
      w_flash = r_flash;
`ifdef TLCM_FAULT_COUNT_EN
      w_fault_count = r_fault_count;
`endif
      case (r_state)
         ST_MON: begin
            if (w_violation) begin
               w_state = ST_FLASH;
               w_fault = 1'b1;
               w_red   = 2'b11;
               w_yel   = 2'b00;
               w_grn   = 2'b00;
               w_flash = '0;
               if (w_conflict)       w_fcode = FC_CONFLICT;
               else if (|w_short)    w_fcode = FC_SHORT_Y;
               else if (|w_illegal)  w_fcode = FC_ILLEGAL;
               else                  w_fcode = FC_INVALID;
`ifdef TLCM_FAULT_COUNT_EN
               if (r_fault_count != 8'hFF) w_fault_count = r_fault_count + 8'd1;
`endif
            end else begin
               for (int a = 0; a < 2; a++) begin
                  if (w_code[a] != C_INV) begin
                     w_red[a]  = (w_code[a] == C_RED);
                     w_yel[a]  = (w_code[a] == C_YEL);
                     w_grn[a]  = (w_code[a] == C_GRN);
                     w_prev[a] = w_code[a];
                     w_icnt[a] = '0;
                     if (w_code[a] != C_YEL)   w_ycnt[a] = '0;
                     else if (r_ycnt[a] != YMAX) w_ycnt[a] = r_ycnt[a] + 1'b1;
                  end else begin
                     // Below IMAX here, otherwise the invalid check above has fired.
                     w_icnt[a] = r_icnt[a] + 1'b1;
                  end
               end
            end
         end
         ST_FLASH: begin
            if (w_clear_ok) begin
               w_state = ST_MON;
               w_fault = 1'b0;
               w_fcode = FC_CONFLICT;
               w_red   = 2'b11;
               w_yel   = 2'b00;
               w_grn   = 2'b00;
               w_prev  = '{C_RED, C_RED};
               w_ycnt  = '{'0, '0};
               w_icnt  = '{'0, '0};
               w_flash = '0;
            end else if (r_flash == FLAST) begin
               w_red   = {~r_red[0], ~r_red[0]};
               w_flash = '0;
            end else begin
               w_flash = r_flash + 1'b1;
            end
         end
         default: w_state = ST_MON;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_MON;
         r_prev  <= '{C_RED, C_RED};
         r_ycnt  <= '{'0, '0};
         r_icnt  <= '{'0, '0};
         r_red   <= 2'b11;
         r_yel   <= 2'b00;
         r_grn   <= 2'b00;
         r_fault <= 1'b0;
         r_fcode <= FC_CONFLICT;
         r_flash <= '0;
`ifdef TLCM_FAULT_COUNT_EN
         r_fault_count <= 8'd0;
`endif
      end else begin
         r_state <= w_state;
         r_prev  <= w_prev;
         r_ycnt  <= w_ycnt;
         r_icnt  <= w_icnt;
         r_red   <= w_red;
         r_yel   <= w_yel;
         r_grn   <= w_grn;
         r_fault <= w_fault;
         r_fcode <= w_fcode;
         r_flash <= w_flash;
`ifdef TLCM_FAULT_COUNT_EN
         r_fault_count <= w_fault_count;
`endif
      end
   end

   assign bus.hw_red     = r_red[0];
   assign bus.hw_yel     = r_yel[0];
   assign bus.hw_grn     = r_grn[0];
   assign bus.fm_red     = r_red[1];
   assign bus.fm_yel     = r_yel[1];
   assign bus.fm_grn     = r_grn[1];
   assign bus.fault      = r_fault;
   assign bus.fault_code = r_fcode;
`ifdef TLCM_FAULT_COUNT_EN
   assign bus.fault_count = r_fault_count;
`endif
endmodule

// File: tb/tb_traffic_light_conflict_monitor.sv
// tb/tb_traffic_light_conflict_monitor.sv - directed bench with a rule-level model checked every cycle
module tb_traffic_light_conflict_monitor;
   localparam int MIN_YELLOW  = 3;
   localparam int INVALID_TOL = 2;
   localparam int FLASH_HALF  = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   traffic_light_conflict_monitor_if bus_if();

   traffic_light_conflict_monitor #(
      .MIN_YELLOW (MIN_YELLOW),
      .INVALID_TOL(INVALID_TOL),
      .FLASH_HALF (FLASH_HALF)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus_if)
   );

   // Model state: per-approach history expressed as run lengths, plus time since fault entry.
   bit m_valid = 0;
   int m_prev[2];
   int m_yrun[2];
   int m_irun[2];
   bit m_fault;
   int m_code;
   int m_since;
   bit m_r[2], m_y[2], m_g[2];
   int m_fcount;

   always @(posedge clk) begin
      int  c[2];
      bit  conf, sh, il, inv;
      c[0] = int'(bus_if.highway_light);
      c[1] = int'(bus_if.farm_light);
      if (rst) begin
         m_valid = 1;
         m_fault = 0; m_code = 0; m_since = 0; m_fcount = 0;
         for (int a = 0; a < 2; a++) begin
            m_prev[a] = 2; m_yrun[a] = 0; m_irun[a] = 0;
            m_r[a] = 1; m_y[a] = 0; m_g[a] = 0;
         end
      end else if (!m_fault) begin
         conf = (c[0] < 2) && (c[1] < 2);
         sh = 0; il = 0; inv = 0;
         for (int a = 0; a < 2; a++) begin
            if (c[a] == 3) begin
               if (m_irun[a] + 1 > INVALID_TOL) inv = 1;
            end else if (m_prev[a] == 1 && c[a] == 2) begin
               if (m_yrun[a] < MIN_YELLOW) sh = 1;
            end else if (!(c[a] == m_prev[a] || (m_prev[a] == 0 && c[a] == 1) ||
                           (m_prev[a] == 2 && c[a] == 0))) begin
               il = 1;
            end
         end
         if (conf || sh || il || inv) begin
            m_fault = 1; m_since = 0;
            m_code = conf ? 0 : sh ? 2 : il ? 1 : 3;
            if (m_fcount < 255) m_fcount++;
            for (int a = 0; a < 2; a++) begin m_r[a] = 1; m_y[a] = 0; m_g[a] = 0; end
         end else begin
            for (int a = 0; a < 2; a++) begin
               if (c[a] == 3) m_irun[a]++;
               else begin
                  m_irun[a] = 0;
                  m_prev[a] = c[a];
                  m_yrun[a] = (c[a] == 1) ? ((m_yrun[a] + 1 > MIN_YELLOW) ? MIN_YELLOW : m_yrun[a] + 1) : 0;
                  m_r[a] = (c[a] == 2); m_y[a] = (c[a] == 1); m_g[a] = (c[a] == 0);
               end
            end
         end
      end else begin
         if (bus_if.clear_fault && c[0] == 2 && c[1] == 2) begin
            m_fault = 0; m_code = 0;
            for (int a = 0; a < 2; a++) begin
               m_prev[a] = 2; m_yrun[a] = 0; m_irun[a] = 0;
               m_r[a] = 1; m_y[a] = 0; m_g[a] = 0;
            end
         end else begin
            m_since++;
            for (int a = 0; a < 2; a++) m_r[a] = ((m_since / FLASH_HALF) % 2) == 0;
         end
      end
   end

   always @(negedge clk) begin
      logic [8:0] got, exp;
      if (m_valid) begin
         got = {bus_if.hw_red, bus_if.hw_yel, bus_if.hw_grn, bus_if.fm_red, bus_if.fm_yel,
                bus_if.fm_grn, bus_if.fault, bus_if.fault_code};
         exp = {m_r[0], m_y[0], m_g[0], m_r[1], m_y[1], m_g[1], m_fault, 2'(m_code)};
         n_tests++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL model_cmp t=%0t got=%b exp=%b", $time, got, exp);
         end
`ifdef TLCM_FAULT_COUNT_EN
         n_tests++;
         if (bus_if.fault_count !== 8'(m_fcount)) begin
            n_fail++;
            $display("FAIL fault_count t=%0t got=%0d exp=%0d", $time, bus_if.fault_count, m_fcount);
         end
`endif
      end
   end

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic step(input logic [1:0] h, input logic [1:0] f, input logic clr);
      bus_if.highway_light = h;
      bus_if.farm_light    = f;
      bus_if.clear_fault   = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      step(2'b10, 2'b10, 1'b1);
      bus_if.clear_fault = 1'b0;
   endtask

   initial begin
      bus_if.highway_light = 2'b10;
      bus_if.farm_light    = 2'b10;
      bus_if.clear_fault   = 1'b0;
      rst = 1'b1;
      step(2'b10, 2'b10, 1'b0);
      step(2'b10, 2'b10, 1'b0);
      rst = 1'b0;
      chk("reset_reds", {6'd0, bus_if.hw_red, bus_if.fm_red}, 8'h03);
      chk("reset_fault", {5'd0, bus_if.fault, bus_if.fault_code}, 8'h00);
      repeat (3) step(2'b10, 2'b10, 1'b0);

      // Normal cycle with a full-length yellow.
      step(2'b00, 2'b10, 1'b0);
      chk("hw_green", {5'd0, bus_if.hw_red, bus_if.hw_yel, bus_if.hw_grn}, 8'h01);
      repeat (3) step(2'b01, 2'b10, 1'b0);
      chk("hw_yellow", {5'd0, bus_if.hw_red, bus_if.hw_yel, bus_if.hw_grn}, 8'h02);
      step(2'b10, 2'b10, 1'b0);
      chk("full_yellow_ok", {7'd0, bus_if.fault}, 8'h00);

      // Short yellow, then flash timing and clear handling.
      step(2'b00, 2'b10, 1'b0);
      repeat (2) step(2'b01, 2'b10, 1'b0);
      step(2'b10, 2'b10, 1'b0);
      chk("short_yel_code", {5'd0, bus_if.fault, bus_if.fault_code}, 8'h06);
      repeat (7) step(2'b10, 2'b10, 1'b0);
      chk("flash_on_7", {7'd0, bus_if.hw_red}, 8'h01);
      step(2'b10, 2'b10, 1'b0);
      chk("flash_off_8", {6'd0, bus_if.hw_red, bus_if.fm_red}, 8'h00);
      step(2'b10, 2'b00, 1'b1);
      chk("clear_ignored", {7'd0, bus_if.fault}, 8'h01);
      do_clear();
      chk("clear_ok", {5'd0, bus_if.fault, bus_if.hw_red, bus_if.fm_red}, 8'h03);
      step(2'b10, 2'b10, 1'b0);

      // Conflict together with an illegal farm R->Y: conflict wins.
      step(2'b00, 2'b01, 1'b0);
      chk("conflict_code", {5'd0, bus_if.fault, bus_if.fault_code}, 8'h04);
      chk("conflict_lamps", {2'd0, bus_if.hw_red, bus_if.hw_yel, bus_if.hw_grn,
                             bus_if.fm_red, bus_if.fm_yel, bus_if.fm_grn}, 8'h24);
      do_clear();

      // Invalid tolerance.
      repeat (2) step(2'b11, 2'b10, 1'b0);
      chk("inv_hold", {6'd0, bus_if.fault, bus_if.hw_red}, 8'h01);
      step(2'b00, 2'b10, 1'b0);
      chk("inv_recover", {6'd0, bus_if.fault, bus_if.hw_grn}, 8'h01);
      repeat (2) step(2'b11, 2'b10, 1'b0);
      chk("inv_two_ok", {6'd0, bus_if.fault, bus_if.hw_grn}, 8'h01);
      step(2'b11, 2'b10, 1'b0);
      chk("inv_code", {5'd0, bus_if.fault, bus_if.fault_code}, 8'h07);
      do_clear();

      // Yellow counter frozen across an invalid sample.
      step(2'b00, 2'b10, 1'b0);
      repeat (2) step(2'b01, 2'b10, 1'b0);
      step(2'b11, 2'b10, 1'b0);
      step(2'b01, 2'b10, 1'b0);
      step(2'b10, 2'b10, 1'b0);
      chk("yel_frozen_ok", {7'd0, bus_if.fault}, 8'h00);

      // Illegal G->R.
      step(2'b00, 2'b10, 1'b0);
      step(2'b10, 2'b10, 1'b0);
      chk("illegal_code", {5'd0, bus_if.fault, bus_if.fault_code}, 8'h05);

      // Reset aborts the flash.
      repeat (3) step(2'b10, 2'b10, 1'b0);
      rst = 1'b1;
      step(2'b10, 2'b10, 1'b0);
      rst = 1'b0;
      chk("rst_abort", {5'd0, bus_if.fault, bus_if.hw_red, bus_if.fm_red}, 8'h03);
      repeat (4) step(2'b10, 2'b10, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
